mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Downstream slave of the read/write request FSM: consumes its level-held `read`/`write` outputs plus address/data, and performs the access on a small internal register array.
- Inserts a fixed number of wait states, then returns a one-cycle `ack` that releases the FSM back to IDLE.
- Serves as the memory-side model/endpoint for the FSM subsystem and its coverage benches.

Parameters:
- DATA_W, 8, data width of storage words, `wdata` and `rdata`.
- ADDR_W, 4, address width; storage depth is 2**ADDR_W words.
- WAIT_CYCLES, 2, wait states between request capture and `ack`; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- read  input  1  level request from upstream FSM; held until ack.
- write  input  1  level request from upstream FSM; held until ack.
- addr  input  ADDR_W  word address; sampled at request capture only.
- wdata  input  DATA_W  write data; sampled at request capture only.
- ack  output  1  one-cycle completion pulse, registered.
- rdata  output  DATA_W  read data, registered, valid in the ack cycle of a read, held afterwards.
- busy  output  1  high while a transaction is in flight (state != S_IDLE).

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state=S_IDLE, ack=0, rdata=0, busy=0, wait counter=0, all storage words=0.
  - Reset mid-transaction aborts it: no ack and no storage write.
- States: S_IDLE, S_WAIT, S_RESP.
- S_IDLE: at an edge where read|write=1:
  - capture addr, wdata and op (write if `write`=1, else read);
  - go to S_WAIT with counter=WAIT_CYCLES-1, or straight to S_RESP if WAIT_CYCLES=0.
- S_WAIT: decrement counter each cycle; at an edge with counter==0, go to S_RESP.
- Entering S_RESP (same edge):
  - ack register set to 1;
  - write op: storage[addr_q] <= wdata_q;
  - read op: rdata <= storage[addr_q].
- S_RESP: lasts exactly one cycle (the ack cycle); read/write are ignored; next state S_IDLE, ack cleared.
- Latency: request first high in cycle T gives ack high only in cycle T+1+WAIT_CYCLES.
- After ack, the upstream FSM returns to IDLE at the next edge, so `read`/`write` are low in S_IDLE. No re-trigger on the request that ack just released.
- Earliest next capture is the cycle after the ack cycle.
- Request deasserted before ack (non-compliant upstream): the transaction still completes and ack still pulses.
- read & write both high at capture: illegal; write takes priority. A simulation-only assertion flags it.
- Inputs changing after capture do not affect the transaction in flight.
- rdata changes only at a read completion or at reset; unchanged by writes.
- Read of an address written in the immediately preceding transaction returns the new data.
- Counter width max(1, $clog2(WAIT_CYCLES+1)); no wrap is possible within the legal range.

Optional Feature:
- Macro: MEM_RESPONDER_STATS_EN.
- Defined:
  - adds outputs rd_count[15:0] and wr_count[15:0];
  - each increments by 1 on the edge entering S_RESP for its op type;
  - both wrap 16'hFFFF -> 0 and reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_responder_pkg holds:
  - state_e enum, 2-bit: S_IDLE=2'b00, S_WAIT=2'b01, S_RESP=2'b10; default transition to S_IDLE.
  - op_e enum: OP_READ=1'b0, OP_WRITE=1'b1.
- One sub-module: mem_responder_wait_cnt, a loadable down-counter with load/en inputs and a zero flag. Everything else stays in mem_responder.

Test Plan:
- Reset: hold reset 3 cycles, release -> ack=0, busy=0, rdata=0; read of addr 4'h7 returns 8'h00.
- Write then read, WAIT_CYCLES=2:
  - write=1, addr=4'h3, wdata=8'hA5 from cycle T -> ack only in T+3, busy high T+1..T+3.
  - Later read of addr 4'h3 -> rdata=8'hA5 in its ack cycle.
- Zero wait, WAIT_CYCLES=0: read of addr 4'h0 after writing 8'h5A -> ack in T+1, rdata=8'h5A; back-to-back write/read to addr 4'hF at minimum spacing -> each acked exactly once.
- Mid-transaction reset: write addr 4'h2, wdata 8'hFF, assert reset in the first S_WAIT cycle -> no ack; later read of 4'h2 returns 8'h00.
- Input change after capture: read of addr 4'h1, addr driven to 4'h9 one cycle later -> rdata equals storage[1].
- Stats (MEM_RESPONDER_STATS_EN defined): 3 writes + 2 reads -> wr_count=3, rd_count=2; preload wr_count to 16'hFFFF via forced stimulus, one write -> wr_count=0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM state encoding, operation type and counter sizing.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Wide enough to hold WAIT_CYCLES-1, never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_responder_wait_cnt.sv
// Loadable down-counter that times the wait states; saturates at zero and flags it.
module mem_responder_wait_cnt
  import mem_responder_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint for the request FSM: fixed wait states, then a one-cycle ack.
// Optional MEM_RESPONDER_STATS_EN adds rd_count/wr_count completion counters.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                cnt_load, cnt_en, cnt_zero;
  logic                enter_resp;

  mem_responder_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (CNT_LOAD),
    .zero     (cnt_zero)
  );

  // op_d/addr_d/wdata_d carry the live request on the capture edge, so the
  // zero-wait case can complete on that same edge.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          op_d     = write ? OP_WRITE : OP_READ;
          addr_d   = addr;
          wdata_d  = wdata;
          cnt_load = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d   = enter_resp;
    rdata_d = rdata_q;
    mem_d   = mem_q;
    if (enter_resp) begin
      if (op_d == OP_WRITE) begin
        mem_d[addr_d] = wdata_d;
      end else begin
        rdata_d = mem_q[addr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (enter_resp) begin
      if (op_d == OP_WRITE) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

`ifndef SYNTHESIS
  a_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_IDLE) |-> !(read && write));
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: dut_a uses two wait states, dut_b zero wait states.
// Stats checks are compiled only when MEM_RESPONDER_STATS_EN is defined.
module tb_mem_responder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, read_a, write_a, ack_a, busy_a;
  logic [3:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       reset_b, read_b, write_b, ack_b, busy_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b, rdata_b;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_count_a, wr_count_a, rd_count_b, wr_count_b;
`endif

  int total = 0;
  int bad   = 0;

  mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset_a), .read(read_a), .write(write_a),
    .addr(addr_a), .wdata(wdata_a), .ack(ack_a), .rdata(rdata_a), .busy(busy_a)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(rd_count_a), .wr_count(wr_count_a)
`endif
  );

  mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset_b), .read(read_b), .write(write_b),
    .addr(addr_b), .wdata(wdata_b), .ack(ack_b), .rdata(rdata_b), .busy(busy_b)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(rd_count_b), .wr_count(wr_count_b)
`endif
  );

  // Drives one level-held request from a negedge; lat is cycles until ack (-1 if none).
  task automatic run_xact(input bit use_b, input bit is_wr, input logic [3:0] a,
                          input logic [7:0] d, output int lat, output logic [7:0] rd);
    lat = -1;
    rd  = '0;
    if (use_b) begin
      write_b = is_wr; read_b = !is_wr; addr_b = a; wdata_b = d;
    end else begin
      write_a = is_wr; read_a = !is_wr; addr_a = a; wdata_a = d;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (use_b ? ack_b : ack_a) begin
        lat = k;
        rd  = use_b ? rdata_b : rdata_a;
        break;
      end
    end
    if (use_b) begin
      write_b = 1'b0; read_b = 1'b0;
    end else begin
      write_a = 1'b0; read_a = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int         lat;
    logic [7:0] rd;
    reset_a = 1'b1; read_a = 1'b0; write_a = 1'b0; addr_a = '0; wdata_a = '0;
    reset_b = 1'b1; read_b = 1'b0; write_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;
    total++; if (ack_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack_a: got %b expected 0", ack_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_a: got %b expected 0", busy_a); end
    total++; if (rdata_a !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata_a: got %h expected 00", rdata_a); end
    total++; if (ack_b !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack_b: got %b expected 0", ack_b); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_b: got %b expected 0", busy_b); end
    total++; if (rdata_b !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata_b: got %h expected 00", rdata_b); end
    run_xact(1'b0, 1'b0, 4'h7, 8'h00, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL reset_read7_latency: got %0d expected 3", lat); end
    total++; if (rd !== 8'h00) begin bad++; $display("[TB] FAIL reset_read7_data: got %h expected 00", rd); end
  endtask

`ifdef MEM_RESPONDER_STATS_EN
  task automatic test_stats();
    int         lat;
    logic [7:0] rd;
    run_xact(1'b1, 1'b1, 4'h1, 8'h11, lat, rd);
    run_xact(1'b1, 1'b1, 4'h2, 8'h22, lat, rd);
    run_xact(1'b1, 1'b1, 4'h3, 8'h33, lat, rd);
    run_xact(1'b1, 1'b0, 4'h1, 8'h00, lat, rd);
    total++; if (rd !== 8'h11) begin bad++; $display("[TB] FAIL stats_read1: got %h expected 11", rd); end
    run_xact(1'b1, 1'b0, 4'h2, 8'h00, lat, rd);
    total++; if (rd !== 8'h22) begin bad++; $display("[TB] FAIL stats_read2: got %h expected 22", rd); end
    total++; if (wr_count_b !== 16'd3) begin bad++; $display("[TB] FAIL stats_wr_count: got %0d expected 3", wr_count_b); end
    total++; if (rd_count_b !== 16'd2) begin bad++; $display("[TB] FAIL stats_rd_count: got %0d expected 2", rd_count_b); end
    force dut_b.wr_cnt_q = 16'hFFFF;
    #1;
    release dut_b.wr_cnt_q;
    @(negedge clk);
    run_xact(1'b1, 1'b1, 4'h4, 8'h44, lat, rd);
    total++; if (wr_count_b !== 16'h0000) begin bad++; $display("[TB] FAIL stats_wr_wrap: got %h expected 0000", wr_count_b); end
    total++; if (rd_count_b !== 16'd2) begin bad++; $display("[TB] FAIL stats_rd_after_wrap: got %0d expected 2", rd_count_b); end
  endtask
`endif

  task automatic test_write_read();
    int         lat;
    logic [7:0] rd;
    logic       exp_ack, exp_busy;
    write_a = 1'b1; addr_a = 4'h3; wdata_a = 8'hA5;
    total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL wr_busy_T: got %b expected 0", busy_a); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_ack  = (k == 3);
      exp_busy = (k <= 3);
      total++; if (ack_a !== exp_ack) begin bad++; $display("[TB] FAIL wr_ack_T+%0d: got %b expected %b", k, ack_a, exp_ack); end
      total++; if (busy_a !== exp_busy) begin bad++; $display("[TB] FAIL wr_busy_T+%0d: got %b expected %b", k, busy_a, exp_busy); end
      if (k == 3) write_a = 1'b0;
    end
    total++; if (rdata_a !== 8'h00) begin bad++; $display("[TB] FAIL wr_rdata_unchanged: got %h expected 00", rdata_a); end
    run_xact(1'b0, 1'b0, 4'h3, 8'h00, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL rd3_latency: got %0d expected 3", lat); end
    total++; if (rd !== 8'hA5) begin bad++; $display("[TB] FAIL rd3_data: got %h expected a5", rd); end
  endtask

  task automatic test_zero_wait();
    int         lat;
    int         acks;
    logic [7:0] rd;
    run_xact(1'b1, 1'b1, 4'h0, 8'h5A, lat, rd);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL zw_write_latency: got %0d expected 1", lat); end
    run_xact(1'b1, 1'b0, 4'h0, 8'h00, lat, rd);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL zw_read_latency: got %0d expected 1", lat); end
    total++; if (rd !== 8'h5A) begin bad++; $display("[TB] FAIL zw_read_data: got %h expected 5a", rd); end
    acks = 0;
    write_b = 1'b1; addr_b = 4'hF; wdata_b = 8'h3C;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (ack_b === 1'b1) acks++;
      if (k == 1) begin
        total++; if (ack_b !== 1'b1) begin bad++; $display("[TB] FAIL b2b_write_ack: got %b expected 1", ack_b); end
        write_b = 1'b0;
        read_b  = 1'b1;
      end else if (k == 2) begin
        total++; if (ack_b !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap_ack: got %b expected 0", ack_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap_busy: got %b expected 0", busy_b); end
      end else if (k == 3) begin
        total++; if (ack_b !== 1'b1) begin bad++; $display("[TB] FAIL b2b_read_ack: got %b expected 1", ack_b); end
        total++; if (rdata_b !== 8'h3C) begin bad++; $display("[TB] FAIL b2b_read_data: got %h expected 3c", rdata_b); end
        read_b = 1'b0;
      end
    end
    total++; if (acks !== 2) begin bad++; $display("[TB] FAIL b2b_ack_count: got %0d expected 2", acks); end
  endtask

  task automatic test_mid_reset();
    int         lat;
    int         acks;
    logic [7:0] rd;
    write_a = 1'b1; addr_a = 4'h2; wdata_a = 8'hFF;
    @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("[TB] FAIL mr_busy_wait: got %b expected 1", busy_a); end
    reset_a = 1'b1;
    write_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b0;
    total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL mr_busy_after: got %b expected 0", busy_a); end
    total++; if (rdata_a !== 8'h00) begin bad++; $display("[TB] FAIL mr_rdata_cleared: got %h expected 00", rdata_a); end
    acks = (ack_a === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_a === 1'b1) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("[TB] FAIL mr_no_ack: got %0d acks expected 0", acks); end
    run_xact(1'b0, 1'b0, 4'h2, 8'h00, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL mr_read_latency: got %0d expected 3", lat); end
    total++; if (rd !== 8'h00) begin bad++; $display("[TB] FAIL mr_read_data: got %h expected 00", rd); end
  endtask

  task automatic test_input_change();
    int         lat;
    logic [7:0] rd;
    run_xact(1'b0, 1'b1, 4'h1, 8'h77, lat, rd);
    run_xact(1'b0, 1'b1, 4'h9, 8'h99, lat, rd);
    lat = -1;
    rd  = '0;
    read_a = 1'b1; addr_a = 4'h1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack_a === 1'b1) begin
        lat = k;
        rd  = rdata_a;
        break;
      end
      if (k == 1) addr_a = 4'h9;
    end
    read_a = 1'b0;
    @(negedge clk);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL ic_latency: got %0d expected 3", lat); end
    total++; if (rd !== 8'h77) begin bad++; $display("[TB] FAIL ic_data: got %h expected 77", rd); end
  endtask

  initial begin
    test_reset();
`ifdef MEM_RESPONDER_STATS_EN
    test_stats();
`endif
    test_write_read();
    test_zero_wait();
    test_mid_reset();
    test_input_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
